ysyx_23060203_mem_arbiter: RTL and testbench

// Shares the single data-memory port between the instruction-fetch requester
// (IFU, read-only) and the load/store requester (LSU, read/write). Grants one

---
 rtl/ysyx_23060203_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ysyx_23060203_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_mem_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU, with a per-transaction timeout.
// Latency: combinational grant in IDLE; response pulse one cycle after mem_resp_valid (minimum 2 cycles).
// Backpressure: both upstream readys stay low while a transaction is open; responses are never stalled.
module ysyx_23060203_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int PRIO_LSU = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp_err
);

  localparam int STRB_W = DATA_W / 8;
  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e              state_q;
  logic                owner_lsu_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_wen_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_wmask_q;
  logic                ifu_resp_valid_q;
  logic [DATA_W-1:0]   ifu_rdata_q;
  logic                ifu_resp_err_q;
  logic                lsu_resp_valid_q;
  logic [DATA_W-1:0]   lsu_rdata_q;
  logic                lsu_resp_err_q;

  logic                win_ifu;
  logic                win_lsu;
  logic                accept;
  logic                done;
  logic                timeout_hit;
  logic                finish;
  logic [DATA_W-1:0]   resp_rdata_d;
  logic                resp_err_d;

  // Arbitration between simultaneous requests and completion/timeout detection
  always_comb begin
    win_lsu      = lsu_req_valid && ((PRIO_LSU != 0) || !ifu_req_valid);
    win_ifu      = ifu_req_valid && ((PRIO_LSU == 0) || !lsu_req_valid);
    // Zero-latency memory: accept and respond in the same REQ cycle.
    done         = mem_resp_valid &&
                   ((state_q == WAIT) || ((state_q == REQ) && mem_req_ready));
    timeout_hit  = (TIMEOUT != 0) && (state_q != IDLE) && (cnt_q == CNT_LAST) && !done;
    finish       = done || timeout_hit;
    // Writes and timeouts return zero data; timeouts always report an error.
    resp_rdata_d = (timeout_hit || mem_wen_q) ? '0 : mem_rdata;
    resp_err_d   = timeout_hit || mem_resp_err;
  end

  // Readys are gated by rstn so every output reads 0 while reset is held.
  assign ifu_req_ready = rstn && (state_q == IDLE) && win_ifu;
  assign lsu_req_ready = rstn && (state_q == IDLE) && win_lsu;
  assign accept        = ifu_req_ready || lsu_req_ready;

  // Transaction FSM: latch the winner, drive memory, return the response to the owner
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= IDLE;
      owner_lsu_q      <= 1'b0;
      cnt_q            <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_addr_q       <= '0;
      mem_wen_q        <= 1'b0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_rdata_q      <= '0;
      lsu_resp_err_q   <= 1'b0;
    end else begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q         <= REQ;
            mem_req_valid_q <= 1'b1;
            cnt_q           <= '0;
            owner_lsu_q     <= lsu_req_ready;
            if (lsu_req_ready) begin
              mem_addr_q  <= lsu_addr;
              mem_wen_q   <= lsu_wen;
              mem_wdata_q <= lsu_wdata;
              mem_wmask_q <= lsu_wmask;
            end else begin
              mem_addr_q  <= ifu_addr;
              mem_wen_q   <= 1'b0;
              mem_wdata_q <= '0;
              mem_wmask_q <= '0;
            end
          end
        end
        REQ, WAIT: begin
          if (finish) begin
            state_q         <= IDLE;
            mem_req_valid_q <= 1'b0;
            if (owner_lsu_q) begin
              lsu_resp_valid_q <= 1'b1;
              lsu_rdata_q      <= resp_rdata_d;
              lsu_resp_err_q   <= resp_err_d;
            end else begin
              ifu_resp_valid_q <= 1'b1;
              ifu_rdata_q      <= resp_rdata_d;
              ifu_resp_err_q   <= resp_err_d;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if ((state_q == REQ) && mem_req_ready) begin
              state_q         <= WAIT;
              mem_req_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q         <= IDLE;
          mem_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wen        = mem_wen_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign ifu_resp_err   = ifu_resp_err_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign lsu_resp_err   = lsu_resp_err_q;

endmodule

// File: tb/tb_ysyx_23060203_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: two instances (LSU priority with TIMEOUT=8,
// IFU priority with timeout disabled) share all inputs and are each checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_ysyx_23060203_mem_arbiter;

  logic        clk;
  logic        rstn;
  logic        ifu_req_valid;
  logic [31:0] ifu_addr;
  logic        lsu_req_valid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  logic        ifu_req_ready  [2];
  logic        ifu_resp_valid [2];
  logic [31:0] ifu_rdata      [2];
  logic        ifu_resp_err   [2];
  logic        lsu_req_ready  [2];
  logic        lsu_resp_valid [2];
  logic [31:0] lsu_rdata      [2];
  logic        lsu_resp_err   [2];
  logic        mem_req_valid  [2];
  logic [31:0] mem_addr       [2];
  logic        mem_wen        [2];
  logic [31:0] mem_wdata      [2];
  logic [3:0]  mem_wmask      [2];

  int checks = 0;
  int failures = 0;

  ysyx_23060203_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_LSU(1), .TIMEOUT(8)) u_a (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready[0]), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid[0]), .ifu_rdata(ifu_rdata[0]), .ifu_resp_err(ifu_resp_err[0]),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready[0]), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid[0]), .lsu_rdata(lsu_rdata[0]), .lsu_resp_err(lsu_resp_err[0]),
    .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr[0]),
    .mem_wen(mem_wen[0]), .mem_wdata(mem_wdata[0]), .mem_wmask(mem_wmask[0]),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  ysyx_23060203_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_LSU(0), .TIMEOUT(0)) u_b (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready[1]), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid[1]), .ifu_rdata(ifu_rdata[1]), .ifu_resp_err(ifu_resp_err[1]),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready[1]), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid[1]), .lsu_rdata(lsu_rdata[1]), .lsu_resp_err(lsu_resp_err[1]),
    .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr[1]),
    .mem_wen(mem_wen[1]), .mem_wdata(mem_wdata[1]), .mem_wmask(mem_wmask[1]),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[inst%0d] actual=%h required=%h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (one open transaction per instance) ----------------
  function automatic bit prio_lsu(input int k); return (k == 0); endfunction
  function automatic int timeout_of(input int k); return (k == 0) ? 8 : 0; endfunction

  bit          m_busy   [2];
  bit          m_issued [2];
  bit          m_lsu    [2];
  int          m_age    [2];
  logic [31:0] m_addr   [2];
  logic        m_wen    [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_mask   [2];
  bit          e_ip [2], e_lp [2], e_ie [2], e_le [2];
  logic [31:0] e_ir [2], e_lr [2];

  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      bit wi, wl, ri, rl, fin, tmo;
      if (!rstn) begin
        m_busy[k] = 0; m_issued[k] = 0; m_lsu[k] = 0; m_age[k] = 0;
        m_addr[k] = '0; m_wen[k] = 0; m_wdata[k] = '0; m_mask[k] = '0;
        e_ip[k] = 0; e_lp[k] = 0; e_ie[k] = 0; e_le[k] = 0; e_ir[k] = '0; e_lr[k] = '0;
      end
      wl = lsu_req_valid && (prio_lsu(k) || !ifu_req_valid);
      wi = ifu_req_valid && (!prio_lsu(k) || !lsu_req_valid);
      ri = rstn && !m_busy[k] && wi;
      rl = rstn && !m_busy[k] && wl;
      chk("ifu_req_ready", k, ifu_req_ready[k], ri);
      chk("lsu_req_ready", k, lsu_req_ready[k], rl);
      chk("mem_req_valid", k, mem_req_valid[k], m_busy[k] && !m_issued[k]);
      chk("mem_addr", k, mem_addr[k], m_addr[k]);
      chk("mem_wen", k, mem_wen[k], m_wen[k]);
      chk("mem_wmask", k, mem_wmask[k], m_mask[k]);
      if (m_lsu[k]) chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
      chk("ifu_resp_valid", k, ifu_resp_valid[k], e_ip[k]);
      chk("ifu_rdata", k, ifu_rdata[k], e_ir[k]);
      chk("ifu_resp_err", k, ifu_resp_err[k], e_ie[k]);
      chk("lsu_resp_valid", k, lsu_resp_valid[k], e_lp[k]);
      chk("lsu_rdata", k, lsu_rdata[k], e_lr[k]);
      chk("lsu_resp_err", k, lsu_resp_err[k], e_le[k]);
      if (rstn) begin
        e_ip[k] = 0; e_lp[k] = 0;
        if (!m_busy[k]) begin
          if (ri || rl) begin
            m_busy[k] = 1; m_issued[k] = 0; m_age[k] = 0; m_lsu[k] = rl;
            m_addr[k]  = rl ? lsu_addr : ifu_addr;
            m_wen[k]   = rl ? lsu_wen : 1'b0;
            m_mask[k]  = rl ? lsu_wmask : 4'h0;
            m_wdata[k] = lsu_wdata;
          end
        end else begin
          fin = mem_resp_valid && (m_issued[k] || mem_req_ready);
          tmo = (timeout_of(k) != 0) && (m_age[k] == timeout_of(k) - 1) && !fin;
          if (fin || tmo) begin
            m_busy[k] = 0;
            if (m_lsu[k]) begin
              e_lp[k] = 1;
              e_lr[k] = (tmo || m_wen[k]) ? 32'h0 : mem_rdata;
              e_le[k] = tmo ? 1'b1 : mem_resp_err;
            end else begin
              e_ip[k] = 1;
              e_ir[k] = tmo ? 32'h0 : mem_rdata;
              e_ie[k] = tmo ? 1'b1 : mem_resp_err;
            end
          end else begin
            if (mem_req_ready) m_issued[k] = 1;
            m_age[k]++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;
  endtask

  task automatic nedge(); @(negedge clk); endtask
  task automatic settle(); #2; endtask

  initial begin
    rstn = 0; quiet();
    ifu_addr = '0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; mem_rdata = '0;
    nedge(); nedge(); settle();
    chk("rst_mem_req_valid", 0, mem_req_valid[0], 1'b0);
    chk("rst_ifu_rdata", 0, ifu_rdata[0], 32'h0);
    nedge(); rstn = 1;

    // 1: IFU read, memory ready at once, response 2 cycles later
    nedge(); ifu_req_valid = 1; ifu_addr = 32'h8000_0000; settle();
    chk("t1_ifu_ready", 0, ifu_req_ready[0], 1'b1);
    nedge(); ifu_req_valid = 0; mem_req_ready = 1; settle();
    chk("t1_mem_req_valid", 0, mem_req_valid[0], 1'b1);
    chk("t1_mem_addr", 0, mem_addr[0], 32'h8000_0000);
    nedge(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    nedge(); mem_resp_valid = 0; settle();
    chk("t1_ifu_pulse", 0, ifu_resp_valid[0], 1'b1);
    chk("t1_ifu_rdata", 0, ifu_rdata[0], 32'h0000_0413);
    chk("t1_no_lsu_pulse", 0, lsu_resp_valid[0], 1'b0);
    nedge(); settle();
    chk("t1_pulse_one_cycle", 0, ifu_resp_valid[0], 1'b0);

    // 2: simultaneous requests; inst0 favours LSU, inst1 favours IFU (also zero-latency memory)
    nedge(); ifu_req_valid = 1; ifu_addr = 32'h8000_0004; lsu_req_valid = 1; lsu_wen = 0;
    lsu_addr = 32'h8000_0100; settle();
    chk("t2_lsu_wins", 0, lsu_req_ready[0], 1'b1);
    chk("t2_ifu_waits", 0, ifu_req_ready[0], 1'b0);
    chk("t2_ifu_wins", 1, ifu_req_ready[1], 1'b1);
    chk("t2_lsu_waits", 1, lsu_req_ready[1], 1'b0);
    nedge(); lsu_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h1111_1111; settle();
    chk("t2_busy_no_ready", 0, ifu_req_ready[0], 1'b0);
    nedge(); mem_req_ready = 0; mem_resp_valid = 0; settle();
    chk("t2_lsu_pulse", 0, lsu_resp_valid[0], 1'b1);
    chk("t2_lsu_rdata", 0, lsu_rdata[0], 32'h1111_1111);
    chk("t2_ifu_grant_on_pulse", 0, ifu_req_ready[0], 1'b1);
    nedge(); ifu_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h2222_2222;
    nedge(); quiet(); settle();
    chk("t2_ifu_pulse", 0, ifu_resp_valid[0], 1'b1);
    chk("t2_ifu_rdata", 0, ifu_rdata[0], 32'h2222_2222);
    nedge(); ifu_req_valid = 1; lsu_req_valid = 1; settle();
    nedge(); ifu_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h3333_3333; settle();
    chk("t2b_lsu_blocked", 1, lsu_req_ready[1], 1'b0);
    nedge(); mem_req_ready = 0; mem_resp_valid = 0; settle();
    chk("t2b_ifu_pulse", 1, ifu_resp_valid[1], 1'b1);
    chk("t2b_lsu_grant_on_pulse", 1, lsu_req_ready[1], 1'b1);
    nedge(); lsu_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h4444_4444;
    nedge(); quiet(); settle();
    chk("t2b_lsu_rdata", 1, lsu_rdata[1], 32'h4444_4444);

    // 3: LSU write with mem_req_ready held low for 3 cycles
    nedge(); lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0010; lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      nedge(); lsu_req_valid = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'hF; settle();
      chk("t3_mem_addr", 0, mem_addr[0], 32'h8000_0010);
      chk("t3_mem_wdata", 0, mem_wdata[0], 32'hDEAD_BEEF);
      chk("t3_mem_wmask", 0, mem_wmask[0], 4'b0011);
      chk("t3_mem_wen", 0, mem_wen[0], 1'b1);
    end
    nedge(); mem_req_ready = 1;
    nedge(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA; settle();
    chk("t3_wait_no_req", 0, mem_req_valid[0], 1'b0);
    nedge(); mem_resp_valid = 0; settle();
    chk("t3_lsu_pulse", 0, lsu_resp_valid[0], 1'b1);
    chk("t3_write_rdata0", 0, lsu_rdata[0], 32'h0);

    // 4: memory never answers; inst0 times out 8 cycles after REQ entry, inst1 keeps waiting
    nedge(); ifu_req_valid = 1; ifu_addr = 32'h0000_0040; lsu_wen = 0;
    for (int i = 1; i <= 8; i++) begin
      nedge(); ifu_req_valid = 0; settle();
      chk("t4_still_req", 0, mem_req_valid[0], 1'b1);
      chk("t4_no_early_pulse", 0, ifu_resp_valid[0], 1'b0);
    end
    nedge(); settle();
    chk("t4_timeout_pulse", 0, ifu_resp_valid[0], 1'b1);
    chk("t4_timeout_err", 0, ifu_resp_err[0], 1'b1);
    chk("t4_timeout_rdata", 0, ifu_rdata[0], 32'h0);
    chk("t4_req_dropped", 0, mem_req_valid[0], 1'b0);
    chk("t4_disabled_waits", 1, mem_req_valid[1], 1'b1);
    nedge(); mem_resp_valid = 1; mem_rdata = 32'h6666_6666;
    nedge(); mem_resp_valid = 0; settle();
    chk("t4_stray_ignored", 0, ifu_resp_valid[0], 1'b0);
    nedge(); mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h7777_7777;
    nedge(); quiet(); settle();
    chk("t4_late_resp", 1, ifu_resp_valid[1], 1'b1);
    chk("t4_late_err", 1, ifu_resp_err[1], 1'b0);

    // 6: reset while in WAIT aborts silently
    nedge(); lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h0000_0200;
    nedge(); lsu_req_valid = 0; mem_req_ready = 1;
    nedge(); mem_req_ready = 0; rstn = 0; mem_resp_valid = 1; mem_rdata = 32'h9999_9999; settle();
    chk("t6_rst_req_valid", 0, mem_req_valid[0], 1'b0);
    chk("t6_rst_addr", 0, mem_addr[0], 32'h0);
    chk("t6_rst_lsu_rdata", 0, lsu_rdata[0], 32'h0);
    nedge(); rstn = 1; mem_resp_valid = 0; settle();
    chk("t6_no_pulse", 0, lsu_resp_valid[0], 1'b0);
    nedge(); lsu_req_valid = 1; lsu_addr = 32'h0000_0300; settle();
    chk("t6_new_grant", 0, lsu_req_ready[0], 1'b1);
    nedge(); lsu_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h0000_0ABC;
    nedge(); quiet(); settle();
    chk("t6_new_resp", 0, lsu_rdata[0], 32'h0000_0ABC);

    // Randomized traffic; the per-cycle model comparison does the checking
    for (int i = 0; i < 3000; i++) begin
      nedge();
      rstn           = ($urandom_range(0, 499) != 0);
      ifu_req_valid  = ($urandom_range(0, 2) == 0);
      ifu_addr       = $urandom;
      lsu_req_valid  = ($urandom_range(0, 2) == 0);
      lsu_addr       = $urandom;
      lsu_wen        = $urandom_range(0, 1);
      lsu_wdata      = $urandom;
      lsu_wmask      = 4'($urandom);
      mem_req_ready  = $urandom_range(0, 1);
      mem_resp_valid = ($urandom_range(0, 3) == 0);
      mem_rdata      = $urandom;
      mem_resp_err   = ($urandom_range(0, 7) == 0);
    end
    nedge(); rstn = 1; quiet();
    nedge(); nedge(); settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
